mem_issue_queue: RTL and testbench
==================================

// Module: mem_issue_queue
// PURPOSE
//  Parametrised in-order issue queue between the store/load RS and the memory FU(s).
//  Accepts up to N_IN packets/cycle and issues up to N_OUT oldest packets/cycle, gated by consumer credit.
//  Branch-mask aware: mispredict squash kills tagged entries (queue compacts); resolve clears mask bits.
//  Registered free-slot credit goes back to dispatch/RS.
// PARAMETERS
//  DEPTH    8   entries (>=2)
//  N_IN     2   enqueue lanes (= `N_way)
//  N_OUT    1   issue lanes (1..DEPTH)
//  DATA_W   128 opaque payload width (Pre_IS_EX_PACKET minus mask, flattened)
//  BMASK_W  4   branch-mask width (= `width_b_mask)
//  N_CLR    2   mask-bit-clear ports (= `ALU_num)
// PORTS
//  clock         in   1                    clock
//  reset         in   1                    synchronous, active-high reset
//  in_valid      in   N_IN                 enqueue lane valid; valid lanes need not be contiguous
//  in_data       in   N_IN*DATA_W          payload per lane
//  in_bmask      in   N_IN*BMASK_W         branch mask per lane
//  issue_credit  in   $clog2(N_OUT+1)      max entries consumer takes this cycle (0 = stall)
//  squash_en     in   1                    mispredict: kill entries with bmask[squash_bit]=1
//  squash_bit    in   $clog2(BMASK_W)      mask bit index to squash
//  clr_en        in   N_CLR                correct-resolve: clear bit clr_bit[k] in every mask
//  clr_bit       in   N_CLR*$clog2(BMASK_W) bit index per clear port
//  out_valid     out  N_OUT                issue lane valid; contiguous from lane 0
//  out_data      out  N_OUT*DATA_W         payload, lane 0 = oldest
//  out_bmask     out  N_OUT*BMASK_W        mask after this cycle's clears
//  avail_out     out  $clog2(N_IN+1)       registered min(free slots, N_IN)
//  count_out     out  $clog2(DEPTH+1)      registered occupancy
//  empty / full  out  1 each               registered: count==0 / count==DEPTH
//  overflow_err  out  1                    sticky: an enqueue was dropped for lack of space
// BEHAVIOUR
//  Reset: all entries invalid/zero; count_out=0, empty=1, full=0, avail_out=min(DEPTH,N_IN), overflow_err=0.
//   Reset dominates every other input in the same cycle.
//  Storage: age-ordered array; slot 0 = oldest; valid entries always packed at slots 0..count-1.
//  Per-cycle order of evaluation (single combinational pass, one register update):
//   1 squash: if squash_en, invalidate stored AND incoming entries with bmask[squash_bit]=1.
//   2 clear: for each k with clr_en[k], clear bit clr_bit[k] in stored and incoming masks;
//     multiple ports may name the same bit (idempotent). Squash reads mask BEFORE clears.
//   3 compact: remaining stored entries re-packed to slots 0.., age order preserved.
//   4 issue: n_iss = min(issue_credit, N_OUT, survivors); out lane i = survivor i for i<n_iss,
//     else out_valid[i]=0 and out_data/out_bmask=0. Issued entries removed.
//     Outputs are combinational from state+squash+clear; no enqueue->issue bypass (min latency 1 cycle).
//   5 enqueue: surviving incoming lanes appended after remaining entries, lane 0 first (lane 0 older).
//     Space computed after issue (slots freed this cycle are reusable). Lanes that do not fit
//     are dropped, youngest first, and overflow_err set (sticky until reset).
//  Registered outputs reflect the post-update state: count_out=new count, avail_out=min(DEPTH-count,N_IN).
//   Dispatch honouring avail_out never overflows, even with zero credit.
//  Squash of everything + enqueue same cycle: queue holds only surviving incoming lanes.
//  issue_credit > N_OUT is saturated to N_OUT.
// TESTING
//  T1 reset, then in_valid=2'b11 A,B; credit=0 one cycle -> count_out=2, avail_out=2; next cycle
//     credit=1 -> out lane0=A; following cycle lane0=B; then empty=1.
//  T2 DEPTH=8 fill 8 with credit=0 -> full=1, avail_out=0; enqueue 1 more -> dropped, overflow_err=1,
//     count stays 8; same cycle credit=1 plus enqueue 1 -> no drop, count 8.
//  T3 entries masks {0001,0010,0001,0000} (old->young), squash_en bit0 -> survivors 2nd,4th in slots
//     0,1, count_out=2; out lane0 same cycle = 2nd entry only if credit>0.
//  T4 clr_en=2'b11 both bit1, entry mask 0010 -> out_bmask=0000 same cycle; later squash bit1 kills nothing.
//  T5 N_OUT=2, 3 entries, credit=2 -> lanes 0,1 = two oldest; credit=1 -> out_valid=2'b01.
//  T6 reset asserted with full queue + valid enqueue + credit -> next cycle empty=1, out_valid=0, overflow_err=0.

Source files
------------

// File: rtl/mem_issue_queue_if.sv
// Enqueue, issue, squash/clear and status bundle for mem_issue_queue.
// The master side is dispatch/RS plus the memory FU; the queue is the slave.
interface mem_issue_queue_if #(
    parameter int DEPTH   = 8,
    parameter int N_IN    = 2,
    parameter int N_OUT   = 1,
    parameter int DATA_W  = 128,
    parameter int BMASK_W = 4,
    parameter int N_CLR   = 2
);
    localparam int SW  = (BMASK_W > 1) ? $clog2(BMASK_W) : 1;
    localparam int CRW = $clog2(N_OUT + 1);
    localparam int AW  = $clog2(N_IN + 1);
    localparam int CW  = $clog2(DEPTH + 1);

    logic [N_IN-1:0]          in_valid;
    logic [N_IN*DATA_W-1:0]   in_data;
    logic [N_IN*BMASK_W-1:0]  in_bmask;
    logic [CRW-1:0]           issue_credit;
    logic                     squash_en;
    logic [SW-1:0]            squash_bit;
    logic [N_CLR-1:0]         clr_en;
    logic [N_CLR*SW-1:0]      clr_bit;
    logic [N_OUT-1:0]         out_valid;
    logic [N_OUT*DATA_W-1:0]  out_data;
    logic [N_OUT*BMASK_W-1:0] out_bmask;
    logic [AW-1:0]            avail_out;
    logic [CW-1:0]            count_out;
    logic                     empty;
    logic                     full;
    logic                     overflow_err;

    modport master (
        output in_valid, in_data, in_bmask, issue_credit,
        output squash_en, squash_bit, clr_en, clr_bit,
        input  out_valid, out_data, out_bmask,
        input  avail_out, count_out, empty, full, overflow_err
    );

    modport slave (
        input  in_valid, in_data, in_bmask, issue_credit,
        input  squash_en, squash_bit, clr_en, clr_bit,
        output out_valid, out_data, out_bmask,
        output avail_out, count_out, empty, full, overflow_err
    );
endinterface

// File: rtl/mem_issue_queue.sv
// In-order memory issue queue: branch-mask squash/clear, compaction,
// credit-gated issue of the oldest entries and registered free-slot credit.
module mem_issue_queue #(
    parameter int DEPTH   = 8,
    parameter int N_IN    = 2,
    parameter int N_OUT   = 1,
    parameter int DATA_W  = 128,
    parameter int BMASK_W = 4,
    parameter int N_CLR   = 2
) (
    input logic              clock,
    input logic              reset,
    mem_issue_queue_if.slave bus
);
    localparam int SW = (BMASK_W > 1) ? $clog2(BMASK_W) : 1;
    localparam int AW = $clog2(N_IN + 1);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int AVAIL_RST = (DEPTH < N_IN) ? DEPTH : N_IN;

    logic [DATA_W-1:0]  q_data  [DEPTH];
    logic [BMASK_W-1:0] q_bmask [DEPTH];
    logic [CW-1:0]      count;
    logic [AW-1:0]      avail;
    logic               empty_r;
    logic               full_r;
    logic               ovf;

    logic [BMASK_W-1:0] clr_mask;
    logic [DATA_W-1:0]  s_data  [DEPTH];
    logic [BMASK_W-1:0] s_bmask [DEPTH];
    logic [DATA_W-1:0]  n_data  [DEPTH];
    logic [BMASK_W-1:0] n_bmask [DEPTH];
    int                 n_surv;
    int                 n_iss;
    int                 n_cnt;
    int                 n_avail;
    logic               drop;

    assign bus.count_out    = count;
    assign bus.avail_out    = avail;
    assign bus.empty        = empty_r;
    assign bus.full         = full_r;
    assign bus.overflow_err = ovf;

    // Union of all mask bits being resolved correctly this cycle.
    always_comb begin
        clr_mask = '0;
        for (int k = 0; k < N_CLR; k++) begin
            if (bus.clr_en[k]) begin
                clr_mask[bus.clr_bit[k*SW +: SW]] = 1'b1;
            end
        end
    end

    // Squash, clear, compact, issue and enqueue in one pass.
    always_comb begin
        int cred;
        logic [BMASK_W-1:0] lm;
        s_data    = '{default: '0};
        s_bmask   = '{default: '0};
        n_data    = '{default: '0};
        n_bmask   = '{default: '0};
        bus.out_valid = '0;
        bus.out_data  = '0;
        bus.out_bmask = '0;
        drop      = 1'b0;
        n_surv    = 0;
        lm        = '0;

        // squash reads the pre-clear mask; survivors get packed from slot 0
        for (int i = 0; i < DEPTH; i++) begin
            if (i < int'(count)) begin
                if (!(bus.squash_en && q_bmask[i][bus.squash_bit])) begin
                    s_data[IW'(n_surv)]  = q_data[i];
                    s_bmask[IW'(n_surv)] = q_bmask[i] & ~clr_mask;
                    n_surv = n_surv + 1;
                end
            end
        end

        cred = int'(bus.issue_credit);
        if (cred > N_OUT) cred = N_OUT;
        n_iss = (cred < n_surv) ? cred : n_surv;

        for (int l = 0; l < N_OUT; l++) begin
            if (l < n_iss) begin
                bus.out_valid[l] = 1'b1;
                bus.out_data[l*DATA_W +: DATA_W]    = s_data[l];
                bus.out_bmask[l*BMASK_W +: BMASK_W] = s_bmask[l];
            end
        end

        // shift out the issued entries
        for (int j = 0; j < DEPTH; j++) begin
            if (j + n_iss < n_surv) begin
                n_data[j]  = s_data[IW'(j + n_iss)];
                n_bmask[j] = s_bmask[IW'(j + n_iss)];
            end
        end
        n_cnt = n_surv - n_iss;

        // lane 0 is older; lanes that no longer fit are lost
        for (int l = 0; l < N_IN; l++) begin
            lm = bus.in_bmask[l*BMASK_W +: BMASK_W];
            if (bus.in_valid[l] && !(bus.squash_en && lm[bus.squash_bit])) begin
                if (n_cnt < DEPTH) begin
                    n_data[IW'(n_cnt)]  = bus.in_data[l*DATA_W +: DATA_W];
                    n_bmask[IW'(n_cnt)] = lm & ~clr_mask;
                    n_cnt = n_cnt + 1;
                end else begin
                    drop = 1'b1;
                end
            end
        end

        n_avail = ((DEPTH - n_cnt) < N_IN) ? (DEPTH - n_cnt) : N_IN;
    end

    // State and registered status update; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            q_data  <= '{default: '0};
            q_bmask <= '{default: '0};
            count   <= '0;
            avail   <= AW'(AVAIL_RST);
            empty_r <= 1'b1;
            full_r  <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            q_data  <= n_data;
            q_bmask <= n_bmask;
            count   <= CW'(n_cnt);
            avail   <= AW'(n_avail);
            empty_r <= (n_cnt == 0);
            full_r  <= (n_cnt == DEPTH);
            ovf     <= ovf | drop;
        end
    end
endmodule

// File: tb/tb_mem_issue_queue.sv
// Directed-vector bench for mem_issue_queue: one DUT with a single issue
// lane and a second with two issue lanes.
module tb_mem_issue_queue;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int total = 0;
    int passed = 0;

    always #5 clock = ~clock;

    mem_issue_queue_if #(.N_OUT(1)) b0();
    mem_issue_queue_if #(.N_OUT(2)) b1();

    mem_issue_queue #(.N_OUT(1)) dut0 (.clock(clock), .reset(reset), .bus(b0));
    mem_issue_queue #(.N_OUT(2)) dut1 (.clock(clock), .reset(reset), .bus(b1));

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drv0(input logic [1:0] v, input logic [127:0] d0, input logic [127:0] d1,
                        input logic [3:0] m0, input logic [3:0] m1, input logic cr);
        b0.in_valid = v;
        b0.in_data = {d1, d0};
        b0.in_bmask = {m1, m0};
        b0.issue_credit = cr;
    endtask

    task automatic idle_all;
        drv0(2'b00, '0, '0, '0, '0, 1'b0);
        b0.squash_en = 0; b0.squash_bit = 0; b0.clr_en = 0; b0.clr_bit = 0;
        b1.in_valid = 0; b1.in_data = 0; b1.in_bmask = 0; b1.issue_credit = 0;
        b1.squash_en = 0; b1.squash_bit = 0; b1.clr_en = 0; b1.clr_bit = 0;
    endtask

    task automatic do_reset;
        idle_all();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset;
        do_reset();
        #1;
        total++; if (b0.count_out !== 0) $display("FAIL rst_count got %0d exp 0", b0.count_out); else passed++;
        total++; if (b0.empty !== 1'b1) $display("FAIL rst_empty got %b exp 1", b0.empty); else passed++;
        total++; if (b0.full !== 1'b0) $display("FAIL rst_full got %b exp 0", b0.full); else passed++;
        total++; if (b0.avail_out !== 2) $display("FAIL rst_avail got %0d exp 2", b0.avail_out); else passed++;
        total++; if (b0.overflow_err !== 1'b0) $display("FAIL rst_ovf got %b exp 0", b0.overflow_err); else passed++;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL rst_oval got %b exp 0", b0.out_valid); else passed++;
    endtask

    task automatic test_basic;
        do_reset();
        drv0(2'b11, 'h11, 'h22, 4'd0, 4'd0, 1'b0);
        #1;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL t1_bypass got %b exp 0", b0.out_valid); else passed++;
        tick();
        total++; if (b0.count_out !== 2) $display("FAIL t1_count got %0d exp 2", b0.count_out); else passed++;
        total++; if (b0.avail_out !== 2) $display("FAIL t1_avail got %0d exp 2", b0.avail_out); else passed++;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL t1_nocred got %b exp 0", b0.out_valid); else passed++;
        drv0(2'b00, '0, '0, 4'd0, 4'd0, 1'b1);
        #1;
        total++; if (b0.out_valid !== 1'b1) $display("FAIL t1_val0 got %b exp 1", b0.out_valid); else passed++;
        total++; if (b0.out_data !== 128'h11) $display("FAIL t1_a got %h exp 11", b0.out_data); else passed++;
        tick();
        total++; if (b0.out_data !== 128'h22) $display("FAIL t1_b got %h exp 22", b0.out_data); else passed++;
        total++; if (b0.count_out !== 1) $display("FAIL t1_cnt1 got %0d exp 1", b0.count_out); else passed++;
        tick();
        total++; if (b0.empty !== 1'b1) $display("FAIL t1_empty got %b exp 1", b0.empty); else passed++;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL t1_drained got %b exp 0", b0.out_valid); else passed++;
    endtask

    task automatic test_overflow;
        logic [127:0] exp_d [8];
        exp_d = '{128'h2, 128'h3, 128'h4, 128'h5, 128'h6, 128'h7, 128'hA, 128'hC};
        do_reset();
        drv0(2'b11, 'h1, 'h2, 4'd0, 4'd0, 1'b0); tick();
        drv0(2'b11, 'h3, 'h4, 4'd0, 4'd0, 1'b0); tick();
        drv0(2'b11, 'h5, 'h6, 4'd0, 4'd0, 1'b0); tick();
        drv0(2'b01, 'h7, 'h0, 4'd0, 4'd0, 1'b0); tick();
        total++; if (b0.count_out !== 7) $display("FAIL t2_cnt7 got %0d exp 7", b0.count_out); else passed++;
        total++; if (b0.avail_out !== 1) $display("FAIL t2_av1 got %0d exp 1", b0.avail_out); else passed++;
        total++; if (b0.overflow_err !== 1'b0) $display("FAIL t2_noovf got %b exp 0", b0.overflow_err); else passed++;
        drv0(2'b11, 'hA, 'hB, 4'd0, 4'd0, 1'b0); tick();
        total++; if (b0.count_out !== 8) $display("FAIL t2_cnt8 got %0d exp 8", b0.count_out); else passed++;
        total++; if (b0.full !== 1'b1) $display("FAIL t2_full got %b exp 1", b0.full); else passed++;
        total++; if (b0.avail_out !== 0) $display("FAIL t2_av0 got %0d exp 0", b0.avail_out); else passed++;
        total++; if (b0.overflow_err !== 1'b1) $display("FAIL t2_ovf got %b exp 1", b0.overflow_err); else passed++;
        drv0(2'b01, 'hC, 'h0, 4'd0, 4'd0, 1'b1);
        #1;
        total++; if (b0.out_data !== 128'h1) $display("FAIL t2_iss got %h exp 1", b0.out_data); else passed++;
        tick();
        total++; if (b0.count_out !== 8) $display("FAIL t2_swap got %0d exp 8", b0.count_out); else passed++;
        drv0(2'b00, '0, '0, 4'd0, 4'd0, 1'b1);
        #1;
        for (int i = 0; i < 8; i++) begin
            total++;
            if (b0.out_data !== exp_d[i])
                $display("FAIL t2_drain%0d got %h exp %h", i, b0.out_data, exp_d[i]);
            else passed++;
            tick();
        end
        total++; if (b0.empty !== 1'b1) $display("FAIL t2_empty got %b exp 1", b0.empty); else passed++;
    endtask

    task automatic test_squash;
        do_reset();
        drv0(2'b11, 'h1, 'h2, 4'b0001, 4'b0010, 1'b0); tick();
        drv0(2'b11, 'h3, 'h4, 4'b0001, 4'b0000, 1'b0); tick();
        total++; if (b0.count_out !== 4) $display("FAIL t3_cnt4 got %0d exp 4", b0.count_out); else passed++;
        drv0(2'b11, 'h5, 'h6, 4'b0001, 4'b0100, 1'b0);
        b0.squash_en = 1'b1; b0.squash_bit = 2'd0;
        #1;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL t3_cr0 got %b exp 0", b0.out_valid); else passed++;
        b0.issue_credit = 1'b1;
        #1;
        total++; if (b0.out_valid !== 1'b1) $display("FAIL t3_val got %b exp 1", b0.out_valid); else passed++;
        total++; if (b0.out_data !== 128'h2) $display("FAIL t3_d got %h exp 2", b0.out_data); else passed++;
        total++; if (b0.out_bmask !== 4'b0010) $display("FAIL t3_m got %b exp 0010", b0.out_bmask); else passed++;
        tick();
        b0.squash_en = 1'b0;
        drv0(2'b00, '0, '0, 4'd0, 4'd0, 1'b1);
        #1;
        total++; if (b0.count_out !== 2) $display("FAIL t3_cnt2 got %0d exp 2", b0.count_out); else passed++;
        total++; if (b0.out_data !== 128'h4) $display("FAIL t3_d4 got %h exp 4", b0.out_data); else passed++;
        tick();
        total++; if (b0.out_data !== 128'h6) $display("FAIL t3_d6 got %h exp 6", b0.out_data); else passed++;
        tick();
        total++; if (b0.empty !== 1'b1) $display("FAIL t3_empty got %b exp 1", b0.empty); else passed++;
    endtask

    task automatic test_clear;
        do_reset();
        drv0(2'b01, 'h7, 'h0, 4'b0011, 4'd0, 1'b0); tick();
        drv0(2'b10, 'h0, 'h9, 4'd0, 4'b0110, 1'b0);
        b0.clr_en = 2'b11; b0.clr_bit = {2'd1, 2'd1};
        tick();
        b0.clr_en = 2'b00;
        drv0(2'b00, '0, '0, 4'd0, 4'd0, 1'b0);
        total++; if (b0.count_out !== 2) $display("FAIL t4_cnt got %0d exp 2", b0.count_out); else passed++;
        b0.squash_en = 1'b1; b0.squash_bit = 2'd1;
        tick();
        b0.squash_en = 1'b0;
        total++; if (b0.count_out !== 2) $display("FAIL t4_nokill got %0d exp 2", b0.count_out); else passed++;
        b0.issue_credit = 1'b1;
        b0.clr_en = 2'b01; b0.clr_bit = {2'd0, 2'd0};
        #1;
        total++; if (b0.out_bmask !== 4'b0000) $display("FAIL t4_m0 got %b exp 0000", b0.out_bmask); else passed++;
        total++; if (b0.out_data !== 128'h7) $display("FAIL t4_d7 got %h exp 7", b0.out_data); else passed++;
        tick();
        b0.clr_en = 2'b00;
        #1;
        total++; if (b0.out_data !== 128'h9) $display("FAIL t4_d9 got %h exp 9", b0.out_data); else passed++;
        total++; if (b0.out_bmask !== 4'b0100) $display("FAIL t4_m9 got %b exp 0100", b0.out_bmask); else passed++;
        tick();
        total++; if (b0.empty !== 1'b1) $display("FAIL t4_empty got %b exp 1", b0.empty); else passed++;
    endtask

    task automatic test_multi_issue;
        do_reset();
        b1.in_valid = 2'b11; b1.in_data = {128'h2, 128'h1}; tick();
        b1.in_valid = 2'b01; b1.in_data = {128'h0, 128'h3}; tick();
        b1.in_valid = 2'b00; b1.issue_credit = 2'd1;
        #1;
        total++; if (b1.out_valid !== 2'b01) $display("FAIL t5_v1 got %b exp 01", b1.out_valid); else passed++;
        total++; if (b1.out_data[127:0] !== 128'h1) $display("FAIL t5_d1 got %h exp 1", b1.out_data[127:0]); else passed++;
        b1.issue_credit = 2'd2;
        #1;
        total++; if (b1.out_valid !== 2'b11) $display("FAIL t5_v2 got %b exp 11", b1.out_valid); else passed++;
        total++; if (b1.out_data !== {128'h2, 128'h1}) $display("FAIL t5_d12 got %h exp 2_1", b1.out_data); else passed++;
        tick();
        total++; if (b1.count_out !== 1) $display("FAIL t5_cnt got %0d exp 1", b1.count_out); else passed++;
        b1.issue_credit = 2'd3;
        #1;
        total++; if (b1.out_valid !== 2'b01) $display("FAIL t5_sat got %b exp 01", b1.out_valid); else passed++;
        total++; if (b1.out_data !== {128'h0, 128'h3}) $display("FAIL t5_d3 got %h exp 0_3", b1.out_data); else passed++;
        tick();
        total++; if (b1.empty !== 1'b1) $display("FAIL t5_empty got %b exp 1", b1.empty); else passed++;
    endtask

    task automatic test_reset_dominates;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drv0(2'b11, 128'(i), 128'(i + 10), 4'd0, 4'd0, 1'b0);
            tick();
        end
        total++; if (b0.overflow_err !== 1'b1) $display("FAIL t6_pre got %b exp 1", b0.overflow_err); else passed++;
        reset = 1'b1;
        drv0(2'b11, 'h55, 'h66, 4'd0, 4'd0, 1'b1);
        tick();
        reset = 1'b0;
        drv0(2'b00, '0, '0, 4'd0, 4'd0, 1'b1);
        #1;
        total++; if (b0.empty !== 1'b1) $display("FAIL t6_empty got %b exp 1", b0.empty); else passed++;
        total++; if (b0.count_out !== 0) $display("FAIL t6_cnt got %0d exp 0", b0.count_out); else passed++;
        total++; if (b0.out_valid !== 1'b0) $display("FAIL t6_oval got %b exp 0", b0.out_valid); else passed++;
        total++; if (b0.overflow_err !== 1'b0) $display("FAIL t6_ovf got %b exp 0", b0.overflow_err); else passed++;
        total++; if (b0.avail_out !== 2) $display("FAIL t6_av got %0d exp 2", b0.avail_out); else passed++;
    endtask

    initial begin
        idle_all();
        test_reset();
        test_basic();
        test_overflow();
        test_squash();
        test_clear();
        test_multi_issue();
        test_reset_dominates();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
